vslc_eeprom_writer: RTL and testbench

SPI initiator that programs the external serial EEPROM holding the VSLC program image. The EEPROM reader fetches that image over the same pins; this block is the write direction.
- Takes a start address and a byte stream on a valid/ready handshake.
- Issues WREN (0x06) and WRITE (0x02), then the 16-bit address and data, splitting the stream at page boundaries.
- Polls RDSR (0x05) until the write-in-progress bit clears.
- Is muxed onto the shared SPI pins by the core while the core is in program-load mode.

---
 rtl/vslc_spi_pkg.sv | 15 +
 rtl/vslc_spi_byte_shifter.sv | 55 +++++
 rtl/vslc_eeprom_writer.sv | 110 +++++++++++
 tb/tb_vslc_eeprom_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_spi_pkg.sv
// vslc_spi_pkg: SPI EEPROM opcodes, status bit index and writer state encoding
package vslc_spi_pkg;
    localparam logic [7:0] SPI_OP_WREN  = 8'h06;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;
    localparam logic [7:0] SPI_OP_RDSR  = 8'h05;
    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam int SR_WIP = 0;
    typedef enum logic [3:0] {
        ST_IDLE, ST_WREN, ST_GAP_W, ST_WRCMD, ST_ADDR_HI, ST_ADDR_LO,
        ST_DATA, ST_GAP_P, ST_RDSR, ST_RDSR_RD, ST_GAP_R, ST_DONE
    } wr_state_e;
    function automatic logic is_shift(wr_state_e s);
        return s inside {ST_WREN, ST_WRCMD, ST_ADDR_HI, ST_ADDR_LO, ST_DATA, ST_RDSR, ST_RDSR_RD};
    endfunction
endpackage

// File: rtl/vslc_spi_byte_shifter.sv
// vslc_spi_byte_shifter: mode-0 SPI byte engine, MSB first, CLK_DIV clk per SCK half-period
module vslc_spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       cipo,
    output logic       sck,
    output logic       copi,
    output logic [7:0] rx_byte,
    output logic       byte_done
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div_cnt;
    logic [3:0]    half_cnt;
    logic          active;
    logic [7:0]    sr;
    // copi leads the first rise by a full half-period because sr loads on go
    assign copi = sr[7];
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            sr        <= '0;
            rx_byte   <= '0;
            sck       <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!active) begin
                if (go) begin
                    active   <= 1'b1;
                    sr       <= tx_byte;
                    div_cnt  <= '0;
                    half_cnt <= '0;
                end
            end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                div_cnt  <= '0;
                sck      <= ~sck;
                half_cnt <= half_cnt + 4'd1;
                if (!sck) rx_byte <= {rx_byte[6:0], cipo};
                else begin
                    sr <= {sr[6:0], 1'b0};
                    if (half_cnt == 4'd15) begin
                        active    <= 1'b0;
                        byte_done <= 1'b1;
                    end
                end
            end else div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vslc_eeprom_writer.sv
// vslc_eeprom_writer: page-splitting SPI EEPROM programmer (WREN/WRITE/RDSR poll).
// Define VSLC_EEPROM_WRITER_TIMEOUT_EN to bound RDSR polling and report error.
module vslc_eeprom_writer import vslc_spi_pkg::*; #(
    parameter int CLK_DIV    = 4,
    parameter int PAGE_BYTES = 32,
    parameter int CSH_CYCLES = 8,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        spi_sck,
    output logic        spi_copi,
    output logic        spi_sd_oe,
    input  logic        spi_cipo,
    output logic        spi_cs_n
);
    localparam int PW = PAGE_BYTES > 1 ? $clog2(PAGE_BYTES) : 1;
    wr_state_e   state, state_n;
    logic [15:0] addr, gap_cnt;
    logic [7:0]  tx_byte, rx_byte;
    logic        last_q, started, go, byte_done, wip, gap_end, timeout, cs_low_n, unused;
    assign wip      = rx_byte[SR_WIP];
    assign gap_end  = gap_cnt == 16'(CSH_CYCLES - 1);
    assign busy     = state != ST_IDLE && state != ST_DONE;
    assign done     = state == ST_DONE;
    assign wr_ready = go && state == ST_DATA;
    assign cs_low_n = is_shift(state_n);
    assign unused   = ^{rx_byte[7:1], POLL_LIMIT[0]};
`ifdef VSLC_EEPROM_WRITER_TIMEOUT_EN
    logic [15:0] poll_cnt;
    assign timeout = wip && poll_cnt == 16'(POLL_LIMIT);
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
            error    <= 1'b0;
        end else begin
            if (state == ST_GAP_P && state_n == ST_RDSR) poll_cnt <= '0;
            else if (state == ST_RDSR_RD && byte_done) poll_cnt <= poll_cnt + 16'd1;
            if (state == ST_IDLE && start) error <= 1'b0;
            else if (state == ST_GAP_R && gap_end && timeout) error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif
    vslc_spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk(clk), .rst(rst), .go(go), .tx_byte(tx_byte), .cipo(spi_cipo),
        .sck(spi_sck), .copi(spi_copi), .rx_byte(rx_byte), .byte_done(byte_done)
    );
    always_comb begin
        state_n = state;
        // DATA bytes launch only once the source offers one; SCK and CS hold meanwhile
        go = is_shift(state) && !started && (state != ST_DATA || wr_valid);
        tx_byte = state == ST_WREN    ? SPI_OP_WREN  :
                  state == ST_WRCMD   ? SPI_OP_WRITE :
                  state == ST_ADDR_HI ? addr[15:8]   :
                  state == ST_ADDR_LO ? addr[7:0]    :
                  state == ST_DATA    ? wr_data      :
                  state == ST_RDSR    ? SPI_OP_RDSR  : 8'h00;
        case (state)
            ST_IDLE:    if (start) state_n = ST_WREN;
            ST_WREN:    if (byte_done) state_n = ST_GAP_W;
            ST_GAP_W:   if (gap_end) state_n = ST_WRCMD;
            ST_WRCMD:   if (byte_done) state_n = ST_ADDR_HI;
            ST_ADDR_HI: if (byte_done) state_n = ST_ADDR_LO;
            ST_ADDR_LO: if (byte_done) state_n = ST_DATA;
            ST_DATA:    if (byte_done && (last_q || addr[PW-1:0] == '0)) state_n = ST_GAP_P;
            ST_GAP_P:   if (gap_end) state_n = ST_RDSR;
            ST_RDSR:    if (byte_done) state_n = ST_RDSR_RD;
            ST_RDSR_RD: if (byte_done) state_n = ST_GAP_R;
            ST_GAP_R:   if (gap_end) state_n = timeout ? ST_DONE : wip ? ST_RDSR : last_q ? ST_DONE : ST_WREN;
            ST_DONE:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            last_q    <= 1'b0;
            started   <= 1'b0;
            gap_cnt   <= '0;
            spi_cs_n  <= 1'b1;
            spi_sd_oe <= 1'b0;
        end else begin
            state     <= state_n;
            started   <= go || (started && !byte_done);
            gap_cnt   <= state_n == state ? gap_cnt + 16'd1 : 16'd0;
            spi_cs_n  <= !cs_low_n;
            spi_sd_oe <= cs_low_n && state_n != ST_RDSR_RD;
            if (state == ST_IDLE && start) begin
                addr   <= start_addr;
                last_q <= 1'b0;
            end else if (wr_ready) begin
                addr   <= addr + 16'd1;
                last_q <= wr_last;
            end
        end
    end
endmodule

// File: tb/tb_vslc_eeprom_writer.sv
// tb_vslc_eeprom_writer: directed tests against a byte-logging SPI EEPROM model
module tb_vslc_eeprom_writer;
    localparam int CLK_DIV = 4;
    localparam int CSH     = 8;
    logic clk = 0, rst = 1, start = 0, wr_valid = 0, wr_last = 0;
    logic [15:0] start_addr = 16'h0000;
    logic [7:0]  wr_data = 8'h00;
    logic wr_ready, busy, done, error, spi_sck, spi_copi, spi_sd_oe, spi_cipo, spi_cs_n;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    vslc_eeprom_writer #(.CLK_DIV(CLK_DIV), .PAGE_BYTES(32), .CSH_CYCLES(CSH), .POLL_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready), .busy(busy), .done(done),
        .error(error), .spi_sck(spi_sck), .spi_copi(spi_copi), .spi_sd_oe(spi_sd_oe),
        .spi_cipo(spi_cipo), .spi_cs_n(spi_cs_n)
    );

    // EEPROM model: logs bytes per CS window, answers RDSR with WIP for the first wip_polls polls
    string bus_s = "";
    logic [7:0] sh = 8'h00, op = 8'h00;
    int bit_cnt = 0, byte_idx = 0, nbytes = 0, rdsr_cnt = 0, wip_polls = 0;
    time rise_t = 0, hi_t = 0, min_gap = 1000000;
    int sck_bad = 0;
    assign spi_cipo = !spi_cs_n && op == 8'h05 && byte_idx == 1 && bit_cnt == 7 && rdsr_cnt < wip_polls;
    always @(negedge spi_cs_n) begin
        bit_cnt = 0;
        byte_idx = 0;
        if ($time - rise_t < min_gap) min_gap = $time - rise_t;
    end
    always @(posedge spi_cs_n) begin
        rise_t = $time;
        if (op == 8'h05 && byte_idx >= 2) rdsr_cnt++;
        bus_s = {bus_s, "| "};
    end
    always @(posedge spi_sck) begin
        hi_t = $time;
        if (!spi_cs_n) begin
            sh = {sh[6:0], spi_copi};
            bit_cnt++;
            if (bit_cnt == 8) begin
                bus_s = {bus_s, $sformatf("%02h ", sh)};
                if (byte_idx == 0) op = sh;
                byte_idx++;
                nbytes++;
                bit_cnt = 0;
            end
        end
    end
    always @(negedge spi_sck) if (!rst && $time - hi_t != CLK_DIV * 10) sck_bad++;

    // byte source and handshake monitors
    logic [8:0] src[$];
    bit hold = 0;
    int acc = 0, done_cnt = 0, d0 = 0, rate_bad = 0;
    time acc_t = 0;
    always @(negedge clk) begin
        wr_valid = !hold && src.size() > 0;
        wr_data  = src.size() > 0 ? src[0][7:0] : 8'h00;
        wr_last  = src.size() > 0 && src[0][8];
    end
    always @(posedge clk) begin
        if (wr_ready === 1'b1) begin
            acc++;
            if (acc_t > 0 && $time - acc_t < 16 * CLK_DIV * 10) rate_bad++;
            acc_t = $time;
            if (src.size() > 0) void'(src.pop_front());
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic load(input int n, input logic [7:0] first, input logic [7:0] step);
        logic [7:0] b = first;
        src.delete();
        for (int i = 0; i < n; i++) begin
            src.push_back({i == n - 1, b});
            b = b + step;
        end
    endtask

    task automatic kick(input logic [15:0] a);
        @(negedge clk);
        bus_s = "";
        rdsr_cnt = 0;
        acc = 0;
        d0 = done_cnt;
        start_addr = a;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done_cnt == d0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done within %0d cycles", name, k);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_cs_n, spi_sck, spi_copi, spi_sd_oe, busy, done, wr_ready, error} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 10000000",
                     {spi_cs_n, spi_sck, spi_copi, spi_sd_oe, busy, done, wr_ready, error});
        end
        rst = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_page();
        wip_polls = 0;
        load(4, 8'ha1, 8'h11);
        kick(16'h0000);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        wait_done("single");
        checks++;
        if (bus_s != "06 | 02 00 00 a1 b2 c3 d4 | 05 00 | ") begin
            errors++; $display("FAIL single_bus: got '%s' expected '06 | 02 00 00 a1 b2 c3 d4 | 05 00 | '", bus_s);
        end
        checks++;
        if (acc != 4) begin errors++; $display("FAIL single_wr_ready: got %0d expected 4", acc); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
        checks++;
        if ({busy, error} !== 2'b00) begin errors++; $display("FAIL single_idle: got busy/error %b expected 00", {busy, error}); end
    endtask

    task automatic test_page_split();
        wip_polls = 0;
        load(5, 8'h11, 8'h11);
        kick(16'h001e);
        repeat (300) @(negedge clk);
        start_addr = 16'hffff;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done("split");
        checks++;
        if (bus_s != "06 | 02 00 1e 11 22 | 05 00 | 06 | 02 00 20 33 44 55 | 05 00 | ") begin
            errors++; $display("FAIL split_bus: got '%s' expected '06 | 02 00 1e 11 22 | 05 00 | 06 | 02 00 20 33 44 55 | 05 00 | '", bus_s);
        end
        checks++;
        if (acc != 5 || rdsr_cnt != 2) begin
            errors++; $display("FAIL split_counts: got bytes %0d rdsr %0d expected 5 and 2", acc, rdsr_cnt);
        end
    endtask

    task automatic test_wip_poll();
        wip_polls = 3;
        min_gap = 1000000;
        load(2, 8'h5a, 8'h4b);
        kick(16'h0100);
        wait_done("poll");
        checks++;
        if (bus_s != "06 | 02 01 00 5a a5 | 05 00 | 05 00 | 05 00 | 05 00 | ") begin
            errors++; $display("FAIL poll_bus: got '%s' expected '06 | 02 01 00 5a a5 | 05 00 | 05 00 | 05 00 | 05 00 | '", bus_s);
        end
        checks++;
        if (rdsr_cnt != 4) begin errors++; $display("FAIL poll_rdsr_count: got %0d expected 4", rdsr_cnt); end
        checks++;
        if (min_gap < CSH * 10) begin errors++; $display("FAIL poll_cs_gap: got %0t expected >= %0d", min_gap, CSH * 10); end
    endtask

    task automatic test_stall();
        int k = 0, bad = 0;
        wip_polls = 0;
        load(3, 8'h01, 8'h01);
        kick(16'h0040);
        while (acc < 1 && k < 3000) begin @(negedge clk); k++; end
        hold = 1;
        repeat (80) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_cs_n !== 1'b0 || spi_sck !== 1'b0 || wr_ready !== 1'b0) bad++;
        end
        hold = 0;
        checks++;
        if (acc != 1 || bad != 0) begin errors++; $display("FAIL stall_hold: got accepted %0d bad %0d expected 1 and 0", acc, bad); end
        wait_done("stall");
        checks++;
        if (bus_s != "06 | 02 00 40 01 02 03 | 05 00 | ") begin
            errors++; $display("FAIL stall_bus: got '%s' expected '06 | 02 00 40 01 02 03 | 05 00 | '", bus_s);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        wip_polls = 0;
        load(3, 8'h99, 8'h01);
        kick(16'h0000);
        nbytes = 0;
        while (nbytes < 3 && k < 3000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        checks++;
        if ({spi_cs_n, spi_sck, busy} !== 3'b100) begin
            errors++; $display("FAIL mid_reset: got cs_n/sck/busy %b expected 100", {spi_cs_n, spi_sck, busy});
        end
        @(negedge clk);
        rst = 0;
        src.delete();
        repeat (2) @(negedge clk);
        load(2, 8'hc0, 8'h01);
        kick(16'h0080);
        wait_done("after_reset");
        checks++;
        if (bus_s != "06 | 02 00 80 c0 c1 | 05 00 | ") begin
            errors++; $display("FAIL after_reset_bus: got '%s' expected '06 | 02 00 80 c0 c1 | 05 00 | '", bus_s);
        end
    endtask

`ifdef VSLC_EEPROM_WRITER_TIMEOUT_EN
    task automatic test_timeout();
        wip_polls = 1000;
        load(1, 8'h77, 8'h00);
        kick(16'h0200);
        wait_done("timeout");
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_error: got error/busy %b expected 10", {error, busy});
        end
        checks++;
        if (bus_s != "06 | 02 02 00 77 | 05 00 | 05 00 | 05 00 | ") begin
            errors++; $display("FAIL timeout_bus: got '%s' expected '06 | 02 02 00 77 | 05 00 | 05 00 | 05 00 | '", bus_s);
        end
        wip_polls = 0;
        load(1, 8'h88, 8'h00);
        kick(16'h0300);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", error); end
        wait_done("timeout_next");
    endtask
`endif

    initial begin
        test_reset();
        test_single_page();
        test_page_split();
        test_wip_poll();
        test_stall();
        test_reset_mid();
`ifdef VSLC_EEPROM_WRITER_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (rate_bad != 0 || sck_bad != 0) begin
            errors++; $display("FAIL timing: got rate violations %0d sck width violations %0d expected 0 and 0", rate_bad, sck_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
